// File: rtl/ibex_rf_bist_ctrl.sv
// March C- BIST controller for the Ibex register file: halts the core, takes over the
// RF ports, sweeps the writable registers and reports pass/fail/timeout.
//
// state | meaning
// IDLE  | RF owned by core; waiting for start_i
// REQ   | halt requested; waiting for core_idle_i or idle timeout
// RUN   | RF owned by BIST; March C- elements 0..5 in progress
// DONE  | one-cycle completion; pass_o resolved here
module ibex_rf_bist_ctrl #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumRegs     = 32,
    parameter int unsigned StartAddr   = 1,
    parameter int unsigned IdleTimeout = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       core_halt_req_o,
    input  logic                       core_idle_i,
    output logic                       rf_sel_o,
    output logic                       rf_we_o,
    output logic [$clog2(NumRegs)-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]       rf_wdata_o,
    output logic [$clog2(NumRegs)-1:0] rf_raddr_o,
    input  logic [DataWidth-1:0]       rf_rdata_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic                       timeout_o,
    output logic [$clog2(NumRegs)-1:0] fail_addr_o,
    output logic [2:0]                 fail_elem_o
);

    localparam int unsigned AW = $clog2(NumRegs);
    localparam int unsigned TW = $clog2(IdleTimeout + 1);
    localparam logic [AW-1:0] ADDR_LO = AW'(StartAddr);
    localparam logic [AW-1:0] ADDR_HI = AW'(NumRegs - 1);
    localparam logic [DataWidth-1:0] ONES = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RUN, ST_DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      elem_q, elem_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            phase_q, phase_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            timeout_q, timeout_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic [2:0]      fail_elem_q, fail_elem_d;

    logic                 is_down, is_read, is_write, step_last, addr_last;
    logic [DataWidth-1:0] rd_pat, wr_pat;

    // Elements 0 and 5 are single-op; 1..4 alternate read (phase 0) and write (phase 1).
    assign is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign is_read   = (elem_q != 3'd0) && ((elem_q == 3'd5) || !phase_q);
    assign is_write  = (elem_q != 3'd5) && ((elem_q == 3'd0) || phase_q);
    assign step_last = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
    assign addr_last = (addr_q == (is_down ? ADDR_LO : ADDR_HI));
    assign rd_pat    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
    assign wr_pat    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0;

    assign busy_o      = (state_q != ST_IDLE);
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        tmo_cnt_d   = tmo_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        core_halt_req_o = 1'b0;
        rf_sel_o    = 1'b0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        rf_raddr_o  = '0;
        done_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_REQ;
                    tmo_cnt_d   = TW'(IdleTimeout - 1);
                    elem_d      = 3'd0;
                    addr_d      = ADDR_LO;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                end
            end
            ST_REQ: begin
                core_halt_req_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (core_idle_i) begin
                    state_d = ST_RUN;
                end else if (tmo_cnt_q == '0) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TW'(1);
                end
            end
            ST_RUN: begin
                core_halt_req_o = 1'b1;
                rf_sel_o        = 1'b1;
                if (is_read) rf_raddr_o = addr_q;
                if (is_write) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = addr_q;
                    rf_wdata_o = wr_pat;
                end
                if (is_read && (rf_rdata_i != rd_pat) && !fail_q) begin
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                end
                if (step_last) begin
                    phase_d = 1'b0;
                    if (addr_last) begin
                        if (elem_q == 3'd5) begin
                            state_d = ST_DONE;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_HI : ADDR_LO;
                        end
                    end else begin
                        addr_d = is_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                    end
                end else begin
                    phase_d = 1'b1;
                end
                if (abort_i) state_d = ST_IDLE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                pass_d  = !fail_q && !timeout_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // An abort discards everything, including a mismatch captured this same cycle.
        if (abort_i && ((state_q == ST_REQ) || (state_q == ST_RUN))) begin
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            tmo_cnt_q   <= tmo_cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

endmodule

// File: tb/tb_ibex_rf_bist_ctrl.sv
// Scoreboard bench for ibex_rf_bist_ctrl: faulty RF model, March-level reference model,
// directed and randomized runs.
module tb_ibex_rf_bist_ctrl;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam logic [DW-1:0] ONES = '1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i, abort_i;
    logic          core_halt_req_o, core_idle_i;
    logic          rf_sel_o, rf_we_o;
    logic [4:0]    rf_waddr_o, rf_raddr_o;
    logic [DW-1:0] rf_wdata_o, rf_rdata_i;
    logic          busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [4:0]    fail_addr_o;
    logic [2:0]    fail_elem_o;

    ibex_rf_bist_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .core_halt_req_o(core_halt_req_o), .core_idle_i(core_idle_i),
        .rf_sel_o(rf_sel_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int pass; int fail; int tmo; int faddr; int felem; int done_ofs; int sel_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   req_cycle = 0;
    int   sel_cnt = 0;
    int   halt_cnt;
    bit   pending = 0;
    bit   busy_prev = 0;

    // Fault / environment configuration: 0 none, 1 stuck bit, 2 coupling
    int ftype = 0, freg = 0, fbit = 0, agg = 0, vic = 0;
    bit fval = 0;
    int idle_delay = 3;
    bit idle_en = 1;

    logic [DW-1:0] mem [NR];

    always @(posedge clk_i) cycle <= cycle + 1;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) halt_cnt <= 0;
        else if (core_halt_req_o) halt_cnt <= halt_cnt + 1;
        else halt_cnt <= 0;
    end

    assign core_idle_i = idle_en && core_halt_req_o && (halt_cnt >= idle_delay);

    always @(posedge clk_i) begin
        if (rf_sel_o && rf_we_o) begin
            mem[rf_waddr_o] <= rf_wdata_o;
            if (ftype == 2 && int'(rf_waddr_o) == agg && rf_wdata_o == ONES) mem[vic] <= ONES;
        end
    end

    always_comb begin
        rf_rdata_i = mem[rf_raddr_o];
        if (ftype == 1 && int'(rf_raddr_o) == freg) rf_rdata_i[fbit] = fval;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // March C- expressed as element table over a plain array memory.
    function automatic exp_t model(int ft, int fr, int fb, bit fv, int ag, int vc, int d);
        exp_t r;
        logic [DW-1:0] m [NR];
        logic [DW-1:0] v;
        int rexp[6] = '{-1, 0, 1, 0, 1, 0};
        int wpat[6] = '{0, 1, 0, 1, 0, -1};
        int down[6] = '{0, 0, 0, 1, 1, 0};
        int a;
        r = '{default: 0};
        if (d >= 255) begin
            r.tmo = 1; r.done_ofs = 255; r.sel_cycles = 0;
            return r;
        end
        r.sel_cycles = 10 * (NR - 1);
        r.done_ofs   = d + 1 + r.sel_cycles;
        for (int i = 0; i < NR; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < NR - 1; k++) begin
                a = (down[e] != 0) ? (NR - 1 - k) : (1 + k);
                if (rexp[e] >= 0) begin
                    v = m[a];
                    if (ft == 1 && a == fr) v[fb] = fv;
                    if (v != ((rexp[e] == 1) ? ONES : '0) && r.fail == 0) begin
                        r.fail = 1; r.faddr = a; r.felem = e;
                    end
                end
                if (wpat[e] >= 0) begin
                    m[a] = (wpat[e] == 1) ? ONES : '0;
                    if (ft == 2 && a == ag && wpat[e] == 1) m[vc] = ONES;
                end
            end
        end
        r.pass = (r.fail == 0) ? 1 : 0;
        return r;
    endfunction

    // Monitor: pops an expectation on every done_o and checks results.
    exp_t cur;
    initial begin
        forever begin
            @(negedge clk_i);
            if (busy_o && !busy_prev) begin
                req_cycle = cycle;
                sel_cnt   = 0;
            end
            busy_prev = busy_o;
            if (rf_sel_o) sel_cnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got done_o=1 expected no result pending");
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_offset", cycle - req_cycle, cur.done_ofs);
                    chk("sel_cycles", sel_cnt, cur.sel_cycles);
                    chk("fail_o", fail_o, cur.fail);
                    chk("timeout_o", timeout_o, cur.tmo);
                    chk("fail_addr_o", fail_addr_o, cur.faddr);
                    chk("fail_elem_o", fail_elem_o, cur.felem);
                    chk("rf_sel_in_done", rf_sel_o, 0);
                    pending = 1;
                end
            end else if (pending) begin
                chk("pass_o", pass_o, cur.pass);
                chk("fail_o_after", fail_o, cur.fail);
                chk("busy_after_done", busy_o, 0);
                pending = 0;
            end
        end
    end

    task automatic run_test(int ft, int fr, int fb, bit fv, int ag, int vc, int d, bit ien,
                            bit also_abort, bit disturb);
        int i;
        ftype = ft; freg = fr; fbit = fb; fval = fv; agg = ag; vic = vc;
        idle_delay = d; idle_en = ien;
        exp_q.push_back(model(ft, fr, fb, fv, ag, vc, ien ? d : 1000));
        @(negedge clk_i); start_i = 1'b1; abort_i = also_abort;
        @(negedge clk_i); start_i = 1'b0; abort_i = 1'b0;
        i = 0;
        while (busy_o && i < 1000) begin
            @(negedge clk_i);
            if (disturb && i == 20) begin
                start_i = 1'b1;
                idle_en = 1'b0;
            end else begin
                start_i = 1'b0;
            end
            i++;
        end
        start_i = 1'b0;
        chk("run_terminated", busy_o, 0);
        idle_en = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("done_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_run_cycles(int n, string nm);
        int k, g;
        k = 0; g = 0;
        while (k < n && g < 2000) begin
            @(negedge clk_i);
            if (rf_sel_o) k++;
            g++;
        end
        chk(nm, k, n);
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int ft, fr, fb, ag, vc, d;
        bit fv, ab, ds;
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_sel", rf_sel_o, 0);
        chk("rst_halt", core_halt_req_o, 0);
        chk("rst_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_raddr", rf_raddr_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_fail", fail_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_fail_addr", fail_addr_o, 0);
        chk("rst_fail_elem", fail_elem_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_test(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);       // fault-free
        run_test(1, 5, 7, 1, 0, 0, 3, 1, 0, 0);       // stuck-at-1
        run_test(2, 0, 0, 0, 10, 11, 3, 1, 0, 0);     // coupling
        run_test(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);       // idle never arrives
        run_test(0, 0, 0, 0, 0, 0, 254, 1, 0, 0);     // idle on last REQ cycle
        run_test(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);       // abort with start in IDLE ignored

        // Abort mid-run, after a failure has already been captured
        ftype = 1; freg = 5; fbit = 7; fval = 1; idle_delay = 3; idle_en = 1;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        wait_run_cycles(100, "abort_reach_run");
        chk("abort_pre_fail", fail_o, 1);
        abort_i = 1'b1;
        @(negedge clk_i); abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_sel", rf_sel_o, 0);
        chk("abort_halt", core_halt_req_o, 0);
        chk("abort_we", rf_we_o, 0);
        chk("abort_fail", fail_o, 0);
        chk("abort_pass", pass_o, 0);
        chk("abort_timeout", timeout_o, 0);
        chk("abort_fail_addr", fail_addr_o, 0);
        chk("abort_fail_elem", fail_elem_o, 0);
        repeat (5) @(negedge clk_i);
        run_test(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);

        // Asynchronous reset mid-run
        ftype = 0; idle_delay = 3; idle_en = 1;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        wait_run_cycles(50, "reset_reach_run");
        rst_ni = 1'b0;
        #1;
        chk("arst_sel", rf_sel_o, 0);
        chk("arst_halt", core_halt_req_o, 0);
        chk("arst_we", rf_we_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_waddr", rf_waddr_o, 0);
        chk("arst_wdata", rf_wdata_o, 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
        run_test(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);

        for (int it = 0; it < 12; it++) begin
            ft = $urandom_range(0, 2);
            fr = $urandom_range(1, 31);
            fb = $urandom_range(0, 31);
            fv = 1'($urandom_range(0, 1));
            ag = $urandom_range(1, 31);
            vc = 1 + ((ag - 1 + $urandom_range(1, 30)) % 31);
            d  = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 20);
            ab = 1'($urandom_range(0, 1));
            ds = (d < 10) && ($urandom_range(0, 1) == 1);
            run_test(ft, fr, fb, fv, ag, vc, d, 1, ab, ds);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
